// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard controller bus: stage status in, stall/flush/forward controls out.
// Latency: carries combinational controls plus the registered stall counter.
// Backpressure: none on the bus itself; stalls are the backpressure it conveys.
interface hazard_ctrl_if #(
  parameter int NREAD = 2,
  parameter int NFWD  = 2,
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  localparam int SW = $clog2(NFWD + 1);

  // Pipeline status
  logic [NREAD*AW-1:0] ra_d;
  logic [NREAD*AW-1:0] ra_e;
  logic [AW-1:0]       dst_e;
  logic                wr_e;
  logic                ld_e;
  logic [NFWD*AW-1:0]  dst_fwd;
  logic [NFWD-1:0]     wr_fwd;
  logic                ld_m;
  logic                br_d;
  logic                br_use_d;
  logic                mul_d;
  logic                i_wait;
  logic                d_wait;
  logic                e_wait;
  logic                redirect_w;
  logic                cnt_clr;

  // Controls back to the pipeline
  logic                stall_f;
  logic                stall_d;
  logic                stall_e;
  logic                stall_m;
  logic                flush_d;
  logic                flush_e;
  logic                flush_m;
  logic                flush_w;
  logic [NREAD*SW-1:0] fwd_d;
  logic [NREAD*SW-1:0] fwd_e;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output ra_d, ra_e, dst_e, wr_e, ld_e, dst_fwd, wr_fwd, ld_m, br_d, br_use_d,
           mul_d, i_wait, d_wait, e_wait, redirect_w, cnt_clr,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           fwd_d, fwd_e, stall_cnt
  );

  modport slave (
    input  ra_d, ra_e, dst_e, wr_e, ld_e, dst_fwd, wr_fwd, ld_m, br_d, br_use_d,
           mul_d, i_wait, d_wait, e_wait, redirect_w, cnt_clr,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           fwd_d, fwd_e, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard/forwarding controller with pending-redirect tracking and stall counter.
// Latency: stall/flush/forward controls are combinational; pending flags and counter update on clk.
// Backpressure: memory/E-unit waits and data hazards stall upstream stages; nothing stalls this block.
module hazard_ctrl #(
  parameter int NREAD = 2,
  parameter int NFWD  = 2,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         resetn,
  hazard_ctrl_if.slave bus
);
  localparam int SW = $clog2(NFWD + 1);

  // Two independent flags: bit0 = redirect waiting out an I-fetch, bit1 = waiting out a D-access
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PEND_I  = 2'b01,
    PEND_D  = 2'b10,
    PEND_ID = 2'b11
  } pend_state_e;

  pend_state_e         pendState;
  logic                pendI, pendD;
  logic                mE, mM;
  logic                loadUse, brHaz, mulHaz, hz;
  logic                pStallF, pStallD, pStallE, pStallM;
  logic                pFlushD, pFlushE, pFlushM, pFlushW;
  logic                setI, setD;
  logic                stallF, flushD, flushW;
  logic [NREAD*SW-1:0] fwdD, fwdE;
  logic [CNT_W-1:0]    stallCnt;

  assign pendI = pendState[0];
  assign pendD = pendState[1];

  // Register 0 is hardwired zero, so it never creates a dependency
  function automatic logic match(input logic [AW-1:0] ra, input logic [AW-1:0] dst);
    return (ra != '0) && (ra == dst);
  endfunction

  // Does any D-stage source depend on the E-stage or M-stage destination
  always_comb begin
    mE = 1'b0;
    mM = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      if (match(bus.ra_d[k*AW +: AW], bus.dst_e))        mE = 1'b1;
      if (match(bus.ra_d[k*AW +: AW], bus.dst_fwd[0 +: AW])) mM = 1'b1;
    end
  end

  assign loadUse = bus.ld_e & bus.wr_e & mE;
  assign brHaz   = bus.br_use_d & ((bus.wr_e & mE) | (bus.ld_m & mM));
  assign mulHaz  = bus.mul_d & ((bus.wr_e & mE) | (bus.wr_fwd[0] & mM));
  assign hz      = loadUse | brHaz | mulHaz;

  // Priority resolution of stall/flush: retiring redirect, E busy, D wait, I wait, then hazards
  always_comb begin
    pStallF = 1'b0; pStallD = 1'b0; pStallE = 1'b0; pStallM = 1'b0;
    pFlushD = 1'b0; pFlushE = 1'b0; pFlushM = 1'b0; pFlushW = 1'b0;
    setI    = 1'b0;
    setD    = 1'b0;
    if (bus.redirect_w) begin
      pFlushD = 1'b1; pFlushE = 1'b1; pFlushM = 1'b1; pFlushW = 1'b1;
      // A fetch/access already in flight returns stale data; remember to squash it
      if (bus.i_wait) begin
        pStallF = 1'b1;
        setI    = 1'b1;
      end
      if (bus.d_wait) setD = 1'b1;
    end else if (bus.e_wait) begin
      pStallF = 1'b1; pStallD = 1'b1; pStallE = 1'b1;
      pFlushM = 1'b1;
      if (bus.d_wait) begin
        pStallM = 1'b1;
        pFlushM = 1'b0;
        pFlushW = 1'b1;
      end
    end else if (bus.d_wait) begin
      pStallF = 1'b1; pStallD = 1'b1; pStallE = 1'b1; pStallM = 1'b1;
      pFlushW = 1'b1;
    end else if (bus.i_wait) begin
      pStallF = 1'b1;
      pFlushD = 1'b1;
      if (hz | bus.br_d) begin
        pStallD = 1'b1;
        pFlushD = 1'b0;
        pFlushE = 1'b1;
      end
    end else begin
      pStallF = hz;
      pStallD = hz;
      pFlushE = hz;
      pFlushD = bus.br_d & ~hz;
    end
  end

  // Pending redirects squash the late response on top of whatever priority decided
  assign stallF = pStallF | (pendI & bus.i_wait);
  assign flushD = pFlushD | pendI;
  assign flushW = pFlushW | pendD;

  // Forwarding select per read port; descending scan so the nearest source wins
  always_comb begin
    fwdD = '0;
    fwdE = '0;
    for (int k = 0; k < NREAD; k++) begin
      for (int j = NFWD - 1; j >= 0; j--) begin
        if (bus.wr_fwd[j] && match(bus.ra_d[k*AW +: AW], bus.dst_fwd[j*AW +: AW]))
          fwdD[k*SW +: SW] = SW'(j + 1);
        if (bus.wr_fwd[j] && match(bus.ra_e[k*AW +: AW], bus.dst_fwd[j*AW +: AW]))
          fwdE[k*SW +: SW] = SW'(j + 1);
      end
    end
    // Busy E unit keeps its latched operands; forwarding would corrupt them
    if (bus.e_wait) fwdE = '0;
  end

  // Pending-redirect tracker: a new set wins over a same-cycle clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pendState <= IDLE;
    end else begin
      pendState <= pend_state_e'({setD | (pendD & bus.d_wait),
                                  setI | (pendI & bus.i_wait)});
    end
  end

  // Saturating count of fetch-stall cycles; clear dominates
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stallCnt <= '0;
    end else if (bus.cnt_clr) begin
      stallCnt <= '0;
    end else if (stallF && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  // Controls are held low for the whole time reset is asserted
  assign bus.stall_f   = resetn & stallF;
  assign bus.stall_d   = resetn & pStallD;
  assign bus.stall_e   = resetn & pStallE;
  assign bus.stall_m   = resetn & pStallM;
  assign bus.flush_d   = resetn & flushD;
  assign bus.flush_e   = resetn & pFlushE;
  assign bus.flush_m   = resetn & pFlushM;
  assign bus.flush_w   = resetn & flushW;
  assign bus.fwd_d     = {(NREAD*SW){resetn}} & fwdD;
  assign bus.fwd_e     = {(NREAD*SW){resetn}} & fwdE;
  assign bus.stall_cnt = stallCnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazards, forwarding, pending redirects, counter, reset.
// Latency: checks combinational controls 1-2ns after input change, registered state after posedge.
// Backpressure: n/a; the bench drives all pipeline status directly.
module tb_hazard_ctrl;
  localparam int NREAD = 2;
  localparam int NFWD  = 2;
  localparam int AW    = 5;
  localparam int CNT_W = 4;
  localparam int SW    = $clog2(NFWD + 1);

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  hazard_ctrl_if #(.NREAD(NREAD), .NFWD(NFWD), .AW(AW), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.NREAD(NREAD), .NFWD(NFWD), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of controls: {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w}
  function automatic logic [7:0] ctl();
    return {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
            bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w};
  endfunction

  task automatic idle_inputs();
    bus.ra_d = '0; bus.ra_e = '0; bus.dst_e = '0; bus.wr_e = 1'b0; bus.ld_e = 1'b0;
    bus.dst_fwd = '0; bus.wr_fwd = '0; bus.ld_m = 1'b0; bus.br_d = 1'b0;
    bus.br_use_d = 1'b0; bus.mul_d = 1'b0; bus.i_wait = 1'b0; bus.d_wait = 1'b0;
    bus.e_wait = 1'b0; bus.redirect_w = 1'b0; bus.cnt_clr = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    #2;
    total++; if (ctl() !== 8'h00) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 8'h00); end
    total++; if (bus.fwd_d !== 4'h0) begin bad++; $display("FAIL reset_fwd_d got=%h exp=0", bus.fwd_d); end
    total++; if (bus.fwd_e !== 4'h0) begin bad++; $display("FAIL reset_fwd_e got=%h exp=0", bus.fwd_e); end
    total++; if (bus.stall_cnt !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
    #10 resetn = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    idle_inputs();
    bus.ld_e = 1'b1; bus.wr_e = 1'b1; bus.dst_e = 5'd5; bus.ra_d = {5'd0, 5'd5};
    #1;
    total++; if (ctl() !== 8'b1100_0100) begin bad++; $display("FAIL load_use_p0 got=%b exp=%b", ctl(), 8'b1100_0100); end
    bus.br_d = 1'b1;
    #1;
    total++; if (ctl() !== 8'b1100_0100) begin bad++; $display("FAIL load_use_br got=%b exp=%b", ctl(), 8'b1100_0100); end
    bus.br_d = 1'b0; bus.ra_d = {5'd5, 5'd0};
    #1;
    total++; if (ctl() !== 8'b1100_0100) begin bad++; $display("FAIL load_use_p1 got=%b exp=%b", ctl(), 8'b1100_0100); end
    bus.ra_d = '0; bus.dst_e = 5'd0;
    #1;
    total++; if (ctl() !== 8'h00) begin bad++; $display("FAIL load_use_r0 got=%b exp=%b", ctl(), 8'h00); end
    // Branch compare against a load still in M
    idle_inputs();
    bus.br_use_d = 1'b1; bus.ld_m = 1'b1; bus.dst_fwd = {5'd0, 5'd9}; bus.ra_d = {5'd9, 5'd0};
    #1;
    total++; if (ctl() !== 8'b1100_0100) begin bad++; $display("FAIL branch_haz got=%b exp=%b", ctl(), 8'b1100_0100); end
    // Multi-cycle op on an M-stage result; also checks D forwarding from source 0
    idle_inputs();
    bus.mul_d = 1'b1; bus.wr_fwd = 2'b01; bus.dst_fwd = {5'd0, 5'd3}; bus.ra_d = {5'd0, 5'd3};
    #1;
    total++; if (ctl() !== 8'b1100_0100) begin bad++; $display("FAIL mul_haz got=%b exp=%b", ctl(), 8'b1100_0100); end
    total++; if (bus.fwd_d !== 4'b0001) begin bad++; $display("FAIL fwd_d_src0 got=%b exp=%b", bus.fwd_d, 4'b0001); end
    bus.br_d = 1'b1; bus.mul_d = 1'b0;
    #1;
    total++; if (ctl() !== 8'b0000_1000) begin bad++; $display("FAIL taken_branch got=%b exp=%b", ctl(), 8'b0000_1000); end
    idle_inputs();
    step();
  endtask

  task automatic test_forward();
    idle_inputs();
    bus.wr_fwd = 2'b11; bus.dst_fwd = {5'd7, 5'd7}; bus.ra_e = {5'd7, 5'd0};
    #1;
    total++; if (bus.fwd_e !== 4'b0100) begin bad++; $display("FAIL fwd_e_near got=%b exp=%b", bus.fwd_e, 4'b0100); end
    bus.wr_fwd = 2'b10;
    #1;
    total++; if (bus.fwd_e !== 4'b1000) begin bad++; $display("FAIL fwd_e_far got=%b exp=%b", bus.fwd_e, 4'b1000); end
    bus.wr_fwd = 2'b11; bus.e_wait = 1'b1;
    #1;
    total++; if (bus.fwd_e !== 4'b0000) begin bad++; $display("FAIL fwd_e_ewait got=%b exp=%b", bus.fwd_e, 4'b0000); end
    total++; if (ctl() !== 8'b1110_0010) begin bad++; $display("FAIL ewait_ctl got=%b exp=%b", ctl(), 8'b1110_0010); end
    bus.e_wait = 1'b0; bus.dst_fwd = '0; bus.ra_e = '0;
    #1;
    total++; if (bus.fwd_e !== 4'b0000) begin bad++; $display("FAIL fwd_e_r0 got=%b exp=%b", bus.fwd_e, 4'b0000); end
    idle_inputs();
    step();
  endtask

  task automatic test_redirect_pending();
    // Redirect while an I-fetch is outstanding, then 2 more wait cycles
    idle_inputs();
    bus.redirect_w = 1'b1; bus.i_wait = 1'b1;
    #1;
    total++; if (ctl() !== 8'b1000_1111) begin bad++; $display("FAIL redir_iw got=%b exp=%b", ctl(), 8'b1000_1111); end
    step();
    bus.redirect_w = 1'b0;
    #1;
    total++; if (ctl() !== 8'b1000_1000) begin bad++; $display("FAIL pend_i_c2 got=%b exp=%b", ctl(), 8'b1000_1000); end
    step();
    // Pending flag must still force flush_d even when the branch path would clear it
    bus.br_d = 1'b1;
    #1;
    total++; if (ctl() !== 8'b1100_1100) begin bad++; $display("FAIL pend_i_c3 got=%b exp=%b", ctl(), 8'b1100_1100); end
    step();
    bus.br_d = 1'b0; bus.i_wait = 1'b0;
    #1;
    total++; if (ctl() !== 8'b0000_1000) begin bad++; $display("FAIL pend_i_last got=%b exp=%b", ctl(), 8'b0000_1000); end
    step();
    total++; if (ctl() !== 8'h00) begin bad++; $display("FAIL pend_i_idle got=%b exp=%b", ctl(), 8'h00); end
    // Same with a data access outstanding
    bus.redirect_w = 1'b1; bus.d_wait = 1'b1;
    #1;
    total++; if (ctl() !== 8'b0000_1111) begin bad++; $display("FAIL redir_dw got=%b exp=%b", ctl(), 8'b0000_1111); end
    step();
    bus.redirect_w = 1'b0;
    #1;
    total++; if (ctl() !== 8'b1111_0001) begin bad++; $display("FAIL pend_d_wait got=%b exp=%b", ctl(), 8'b1111_0001); end
    step();
    bus.d_wait = 1'b0;
    #1;
    total++; if (ctl() !== 8'b0000_0001) begin bad++; $display("FAIL pend_d_last got=%b exp=%b", ctl(), 8'b0000_0001); end
    step();
    total++; if (ctl() !== 8'h00) begin bad++; $display("FAIL pend_d_idle got=%b exp=%b", ctl(), 8'h00); end
  endtask

  task automatic test_ed_wait();
    idle_inputs();
    bus.e_wait = 1'b1; bus.d_wait = 1'b1;
    #1;
    total++; if (ctl() !== 8'b1111_0001) begin bad++; $display("FAIL ewait_dwait got=%b exp=%b", ctl(), 8'b1111_0001); end
    bus.d_wait = 1'b0;
    #1;
    total++; if (ctl() !== 8'b1110_0010) begin bad++; $display("FAIL ewait_only got=%b exp=%b", ctl(), 8'b1110_0010); end
    bus.e_wait = 1'b0; bus.d_wait = 1'b1;
    #1;
    total++; if (ctl() !== 8'b1111_0001) begin bad++; $display("FAIL dwait_only got=%b exp=%b", ctl(), 8'b1111_0001); end
    idle_inputs();
    step();
  endtask

  task automatic test_iwait_branch();
    idle_inputs();
    bus.i_wait = 1'b1; bus.br_d = 1'b1;
    #1;
    total++; if (ctl() !== 8'b1100_0100) begin bad++; $display("FAIL iwait_br got=%b exp=%b", ctl(), 8'b1100_0100); end
    bus.br_d = 1'b0;
    #1;
    total++; if (ctl() !== 8'b1000_1000) begin bad++; $display("FAIL iwait_only got=%b exp=%b", ctl(), 8'b1000_1000); end
    bus.i_wait = 1'b0; bus.br_d = 1'b1;
    #1;
    total++; if (ctl() !== 8'b0000_1000) begin bad++; $display("FAIL br_only got=%b exp=%b", ctl(), 8'b0000_1000); end
    idle_inputs();
    step();
  endtask

  task automatic test_counter_reset();
    idle_inputs();
    bus.cnt_clr = 1'b1;
    step();
    total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL cnt_clr0 got=%0d exp=0", bus.stall_cnt); end
    bus.cnt_clr = 1'b0; bus.i_wait = 1'b1;
    repeat (3) step();
    total++; if (bus.stall_cnt !== 4'd3) begin bad++; $display("FAIL cnt_3 got=%0d exp=3", bus.stall_cnt); end
    repeat (17) step();
    total++; if (bus.stall_cnt !== 4'd15) begin bad++; $display("FAIL cnt_sat got=%0d exp=15", bus.stall_cnt); end
    // Clear wins over a concurrent stall
    bus.cnt_clr = 1'b1;
    step();
    total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL cnt_clr_prio got=%0d exp=0", bus.stall_cnt); end
    bus.cnt_clr = 1'b0;
    step();
    total++; if (bus.stall_cnt !== 4'd1) begin bad++; $display("FAIL cnt_after_clr got=%0d exp=1", bus.stall_cnt); end
    // Create pend_i, then reset asynchronously with activity on every input class
    bus.redirect_w = 1'b1;
    step();
    bus.redirect_w = 1'b0;
    bus.wr_fwd = 2'b11; bus.dst_fwd = {5'd4, 5'd4}; bus.ra_d = {5'd4, 5'd4}; bus.ra_e = {5'd4, 5'd4};
    #2 resetn = 1'b0;
    #1;
    total++; if (ctl() !== 8'h00) begin bad++; $display("FAIL arst_ctl got=%b exp=%b", ctl(), 8'h00); end
    total++; if (bus.fwd_d !== 4'h0) begin bad++; $display("FAIL arst_fwd_d got=%h exp=0", bus.fwd_d); end
    total++; if (bus.fwd_e !== 4'h0) begin bad++; $display("FAIL arst_fwd_e got=%h exp=0", bus.fwd_e); end
    total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", bus.stall_cnt); end
    // Release between edges: a surviving pend_i would show up as flush_d
    idle_inputs();
    #1 resetn = 1'b1;
    #1;
    total++; if (ctl() !== 8'h00) begin bad++; $display("FAIL arst_pend_clr got=%b exp=%b", ctl(), 8'h00); end
    step();
    total++; if (ctl() !== 8'h00) begin bad++; $display("FAIL post_rst_idle got=%b exp=%b", ctl(), 8'h00); end
    total++; if (bus.stall_cnt !== 4'd0) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=0", bus.stall_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_forward();
    test_redirect_pending();
    test_ed_wait();
    test_iwait_branch();
    test_counter_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
